seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
- Unsigned radix-2 restoring divider. It is the inverse-direction companion to the arithmetic library's karatsuba multiplier.
- Takes an N-bit dividend and N-bit divisor through a valid/ready input handshake.
- Iterates one quotient bit per clock and presents quotient, remainder and a divide-by-zero flag through a valid/ready output handshake.
- Intended for multiply/divide round-trip checks and for datapaths that need a low-area divide.

Parameters:
- N, 16, operand width in bits (N >= 2).

Ports:
- clk_i  input  1  clock, all state updates on rising edge
- rstn_i  input  1  reset, asynchronous, active-low
- valid_i  input  1  dividend/divisor valid
- ready_o  output  1  divider can accept new operands
- dividend  input  N  unsigned dividend
- divisor  input  N  unsigned divisor
- valid_o  output  1  result valid
- ready_i  input  1  consumer accepts result
- quotient  output  N  floor(dividend/divisor)
- remainder  output  N  dividend mod divisor
- div_by_zero_o  output  1  current result came from a zero divisor

Behaviour:
- Clock and reset: one clock (clk_i); reset rstn_i is asynchronous and active-low.
- Reset values: state=IDLE, ready_o=1, valid_o=0, quotient=0, remainder=0, div_by_zero_o=0, iteration counter=0.
- Internal state: partial remainder R (N+1 bits), shift register Q (N bits), latched divisor D (N bits), counter cnt (ceil(log2(N+1)) bits).
- FSM states:
  - IDLE: ready_o=1, valid_o=0. Accept on the edge where valid_i && ready_o.
    - If divisor==0: go straight to DONE with quotient={N{1}}, remainder=dividend, div_by_zero_o=1.
    - Otherwise: R=0, Q=dividend, D=divisor, cnt=0, go to BUSY.
  - BUSY: ready_o=0, valid_o=0. Each edge does one restoring step:
    - T = {R[N-1:0], Q[N-1]} - {1'b0, D}.
    - If T is non-negative (borrow=0): R=T, Q={Q[N-2:0],1}. Else: R={R[N-1:0],Q[N-1]}, Q={Q[N-2:0],0}.
    - cnt increments. On the edge completing step N (cnt==N-1): quotient=final Q, remainder=final R[N-1:0], div_by_zero_o=0, go to DONE.
  - DONE: ready_o=0, valid_o=1.
    - quotient, remainder and div_by_zero_o are held stable while valid_o && !ready_i.
    - On the edge with ready_i=1, go to IDLE. The result outputs keep their last values; only valid_o drops.
- Latency:
  - Non-zero divisor: valid_o rises exactly N clock edges after the accept edge (16 for N=16).
  - Zero divisor: valid_o rises on the accept edge itself (visible the cycle after acceptance).
- Throughput: one division per N+2 cycles at best (accept, N steps, handoff). No operand accepted while BUSY or DONE.
- Operand sampling: dividend and divisor are sampled only on the accept edge. Later changes while BUSY have no effect.
- valid_i in BUSY/DONE is ignored and not queued. The producer must hold valid_i until ready_o.
- Simultaneous events:
  - In DONE, an edge with ready_i=1 and valid_i=1 only returns to IDLE. The new operands are accepted on a later edge.
  - A back-to-back accept therefore occurs no earlier than one cycle after result handoff.
- Boundary results:
  - dividend < divisor gives quotient=0, remainder=dividend.
  - divisor=1 gives quotient=dividend, remainder=0.
  - dividend=0 gives 0/0 with no flag unless the divisor is also 0.
- Reset mid-operation: asserting rstn_i low in any state immediately forces the reset values. The in-flight result is discarded and no valid_o pulse is produced.
- Invariant at every valid_o (non-zero divisor): quotient*divisor + remainder == dividend, and remainder < divisor.

Test Plan:
- Basic: dividend=16'h921E, divisor=16'h00FF, ready_i=1 -> quotient=16'h0092, remainder=16'h00B0, div_by_zero_o=0, valid_o high exactly 16 edges after accept, high for 1 cycle.
- Extremes:
  - 16'hFFFF / 16'h0001 -> q=16'hFFFF, r=16'h0000.
  - 16'h0005 / 16'h0007 -> q=16'h0000, r=16'h0005.
  - 16'h0000 / 16'h1234 -> q=0, r=0.
- Divide by zero: 16'hB8EF / 16'h0000 -> q=16'hFFFF, r=16'hB8EF, div_by_zero_o=1, valid_o one cycle after accept. The next normal divide clears the flag.
- Backpressure:
  - Hold ready_i=0 for 5 cycles in DONE after 16'hD00D / 16'h0010 -> valid_o stays 1 and q=16'h0D00, r=16'h000D stay stable.
  - valid_i pulses meanwhile are ignored (ready_o=0).
  - Raising ready_i returns to IDLE next edge.
- Reset mid-operation: accept 16'h8888 / 16'h0003, deassert rstn_i 7 cycles later -> all outputs return to reset values asynchronously with no valid_o. After release, a new divide 16'hAAAA / 16'h0002 gives q=16'h5555, r=0.
- Randomised round-trip: 1000 random operand pairs, including divisor 0/1 and 16'hFFFF -> every result satisfies q*d+r==dividend and r<d, with latency exactly 16.

Source files
------------

// File: rtl/seq_divider.sv
// Unsigned radix-2 restoring divider: one quotient bit per clock, valid/ready on both sides.
// A zero divisor short-circuits to an all-ones quotient with the dividend as remainder.
module seq_divider #(
  parameter int unsigned N = 16
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero_o
);

  localparam int unsigned CntW = $clog2(N + 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e          state_q;
  logic [N:0]      r_q;
  logic [N-1:0]    q_q;
  logic [N-1:0]    d_q;
  logic [CntW-1:0] cnt_q;

  logic [N:0]   shifted;
  logic [N:0]   trial;
  logic         borrow;
  logic [N:0]   r_step;
  logic [N-1:0] q_step;

  // Partial remainder stays below D, so bit N of the trial difference is the borrow.
  always_comb begin
    shifted = {r_q[N-1:0], q_q[N-1]};
    trial   = shifted - {1'b0, d_q};
    borrow  = trial[N];
    r_step  = borrow ? shifted : trial;
    q_step  = {q_q[N-2:0], ~borrow};
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q       <= StIdle;
      ready_o       <= 1'b1;
      valid_o       <= 1'b0;
      quotient      <= '0;
      remainder     <= '0;
      div_by_zero_o <= 1'b0;
      r_q           <= '0;
      q_q           <= '0;
      d_q           <= '0;
      cnt_q         <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (valid_i && ready_o) begin
            ready_o <= 1'b0;
            if (divisor == '0) begin
              quotient      <= '1;
              remainder     <= dividend;
              div_by_zero_o <= 1'b1;
              valid_o       <= 1'b1;
              state_q       <= StDone;
            end else begin
              r_q     <= '0;
              q_q     <= dividend;
              d_q     <= divisor;
              cnt_q   <= '0;
              state_q <= StBusy;
            end
          end
        end
        StBusy: begin
          r_q   <= r_step;
          q_q   <= q_step;
          cnt_q <= cnt_q + CntW'(1);
          if (cnt_q == CntW'(N - 1)) begin
            quotient      <= q_step;
            remainder     <= r_step[N-1:0];
            div_by_zero_o <= 1'b0;
            valid_o       <= 1'b1;
            state_q       <= StDone;
          end
        end
        StDone: begin
          if (ready_i) begin
            valid_o <= 1'b0;
            ready_o <= 1'b1;
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
          ready_o <= 1'b1;
          valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Randomised and directed bench for seq_divider, checked against plain a/b and a%b arithmetic.
module tb_seq_divider;

  localparam int unsigned N = 16;

  logic         clk;
  logic         rstn;
  logic         valid_i;
  logic         ready_o;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         valid_o;
  logic         ready_i;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         dbz;

  int checks = 0;
  int errors = 0;

  seq_divider #(.N(N)) dut (
    .clk_i         (clk),
    .rstn_i        (rstn),
    .valid_i       (valid_i),
    .ready_o       (ready_o),
    .dividend      (dividend),
    .divisor       (divisor),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .quotient      (quotient),
    .remainder     (remainder),
    .div_by_zero_o (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Entered and left at 1 time unit after a rising edge.
  task automatic run_div(input logic [N-1:0] a, input logic [N-1:0] b, input int stall);
    logic [N-1:0]    eq;
    logic [N-1:0]    er;
    logic            edbz;
    int              exp_lat;
    int              lat;
    int              waited;
    longint unsigned prod;
    if (b == 0) begin
      eq = '1; er = a; edbz = 1'b1; exp_lat = 0;
    end else begin
      eq = a / b; er = a % b; edbz = 1'b0; exp_lat = N;
    end
    waited = 0;
    while (!ready_o && waited < 50) begin
      @(posedge clk); #1; waited++;
    end
    check("ready_before_accept", ready_o, 1);
    dividend = a; divisor = b; valid_i = 1'b1; ready_i = (stall == 0);
    @(posedge clk); #1;
    valid_i = 1'b0; dividend = N'($urandom); divisor = N'($urandom);
    lat = 0;
    while (!valid_o && lat < N + 10) begin
      @(posedge clk); #1; lat++;
    end
    check("latency", lat, exp_lat);
    check("quotient", quotient, eq);
    check("remainder", remainder, er);
    check("div_by_zero", dbz, edbz);
    check("ready_in_done", ready_o, 0);
    if (b != 0) begin
      prod = longint'(quotient) * longint'(b) + longint'(remainder);
      check("roundtrip", prod, longint'(a));
      check("rem_lt_div", remainder < b, 1);
    end
    for (int i = 0; i < stall; i++) begin
      valid_i = i[0]; dividend = N'($urandom); divisor = N'($urandom);
      @(posedge clk); #1;
      check("stall_valid", valid_o, 1);
      check("stall_quotient", quotient, eq);
      check("stall_remainder", remainder, er);
      check("stall_ready", ready_o, 0);
    end
    valid_i = 1'b0; ready_i = 1'b1;
    @(posedge clk); #1;
    check("handoff_valid", valid_o, 0);
    check("handoff_ready", ready_o, 1);
    check("hold_quotient", quotient, eq);
  endtask

  initial begin
    logic [N-1:0] ra;
    logic [N-1:0] rb;
    rstn = 1'b0; valid_i = 1'b0; ready_i = 1'b1; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", ready_o, 1);
    check("rst_valid", valid_o, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_dbz", dbz, 0);
    rstn = 1'b1;
    @(posedge clk); #1;

    run_div(16'h921E, 16'h00FF, 0);
    run_div(16'hFFFF, 16'h0001, 0);
    run_div(16'h0005, 16'h0007, 0);
    run_div(16'h0000, 16'h1234, 0);
    run_div(16'hB8EF, 16'h0000, 0);
    run_div(16'h1234, 16'h0011, 0);
    check("dbz_cleared", dbz, 0);
    run_div(16'hD00D, 16'h0010, 5);

    // Handoff edge with valid_i high only returns to IDLE; accept comes one edge later.
    dividend = 16'd100; divisor = 16'd7; valid_i = 1'b1; ready_i = 1'b1;
    @(posedge clk); #1;
    repeat (N) @(posedge clk);
    #1;
    check("simul_valid", valid_o, 1);
    check("simul_quotient", quotient, 14);
    check("simul_remainder", remainder, 2);
    dividend = 16'd50; divisor = 16'd5;
    @(posedge clk); #1;
    check("simul_no_accept", ready_o, 1);
    check("simul_valid_drop", valid_o, 0);
    @(posedge clk); #1;
    check("simul_accepted", ready_o, 0);
    valid_i = 1'b0;
    repeat (N) @(posedge clk);
    #1;
    check("simul2_valid", valid_o, 1);
    check("simul2_quotient", quotient, 10);
    check("simul2_remainder", remainder, 0);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of a division.
    dividend = 16'h8888; divisor = 16'h0003; valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check("midrst_valid", valid_o, 0);
    check("midrst_ready", ready_o, 1);
    check("midrst_quotient", quotient, 0);
    check("midrst_remainder", remainder, 0);
    check("midrst_dbz", dbz, 0);
    for (int i = 0; i < N + 2; i++) begin
      @(posedge clk); #1;
      check("midrst_no_valid", valid_o, 0);
    end
    rstn = 1'b1;
    @(posedge clk); #1;
    run_div(16'hAAAA, 16'h0002, 0);

    for (int i = 0; i < 1000; i++) begin
      case ($urandom_range(0, 9))
        0:       rb = '0;
        1:       rb = 16'h0001;
        2:       rb = 16'hFFFF;
        3:       rb = N'($urandom_range(2, 15));
        default: rb = N'($urandom);
      endcase
      case ($urandom_range(0, 9))
        0:       ra = '0;
        1:       ra = 16'hFFFF;
        default: ra = N'($urandom);
      endcase
      run_div(ra, rb, (i % 50 == 0) ? 2 : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
